// File: rtl/func_gen_pkg.sv
// Shared types and constants for the DDS function generator.
package func_gen_pkg;

    typedef enum logic [2:0] {
        SINE     = 3'd0,
        TRIANGLE = 3'd1,
        SQUARE   = 3'd2,
        PWM      = 3'd3,
        SAWTOOTH = 3'd4
    } wave_mode_t;

    // MSB of bram_addr picks the LUT table
    localparam logic LUT_SEL_SINE = 1'b0;
    localparam logic LUT_SEL_TRI  = 1'b1;

endpackage

// File: rtl/dds_phase_acc.sv
// Phase accumulator with wrap detection and shadow/active config registers.
// Pending config is promoted on a phase wrap so a period is never cut short;
// when no wrap can occur (disabled or zero tuning) it is promoted next clock.
module dds_phase_acc
    import func_gen_pkg::*;
#(
    parameter int unsigned PHASE_W = 32,
    parameter int unsigned DATA_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               cfg_load,
    input  logic [PHASE_W-1:0] cfg_tuning,
    input  logic [2:0]         cfg_mode,
    input  logic [DATA_W-1:0]  cfg_amp,
    input  logic [7:0]         cfg_duty,
    output logic [PHASE_W-1:0] phase,
    output logic               wrap,
    output logic [2:0]         mode,
    output logic [DATA_W-1:0]  amp,
    output logic [7:0]         duty
);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               wrap_q;
    logic [PHASE_W-1:0] tuning_q, pend_tuning_q;
    logic [2:0]         mode_q, pend_mode_q;
    logic [DATA_W-1:0]  amp_q, pend_amp_q;
    logic [7:0]         duty_q, pend_duty_q;
    logic               pend_q;
    logic [PHASE_W:0]   sum;
    logic               carry;
    logic               xfer;

    // Next phase, carry-out and pending->active transfer condition
    always_comb begin
        sum     = {1'b0, phase_q} + {1'b0, tuning_q};
        carry   = en & sum[PHASE_W];
        phase_d = en ? sum[PHASE_W-1:0] : phase_q;
        xfer    = pend_q & (~en | (tuning_q == '0) | carry);
    end

    // Phase, wrap flag (aligned with the first phase of a period) and cfg registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q       <= '0;
            wrap_q        <= 1'b0;
            tuning_q      <= '0;
            mode_q        <= SINE;
            amp_q         <= '1;
            duty_q        <= 8'd128;
            pend_q        <= 1'b0;
            pend_tuning_q <= '0;
            pend_mode_q   <= SINE;
            pend_amp_q    <= '1;
            pend_duty_q   <= 8'd128;
        end else begin
            phase_q <= phase_d;
            wrap_q  <= carry;
            if (xfer) begin
                tuning_q <= pend_tuning_q;
                mode_q   <= pend_mode_q;
                amp_q    <= pend_amp_q;
                duty_q   <= pend_duty_q;
            end
            // A load coinciding with a transfer stays pending for the next wrap
            if (cfg_load) begin
                pend_tuning_q <= cfg_tuning;
                pend_mode_q   <= cfg_mode;
                pend_amp_q    <= cfg_amp;
                pend_duty_q   <= cfg_duty;
            end
            pend_q <= cfg_load | (pend_q & ~xfer);
        end
    end

    assign phase = phase_q;
    assign wrap  = wrap_q;
    assign mode  = mode_q;
    assign amp   = amp_q;
    assign duty  = duty_q;

endmodule

// File: rtl/dds_func_gen.sv
// DDS function generator: mode mux, BRAM-latency-matching pipe and amplitude scaler.
// Every mode reaches wave_out BRAM_LAT+2 cycles after its phase stage, so mode
// switches at a wrap never mix samples from different periods.
module dds_func_gen
    import func_gen_pkg::*;
#(
    parameter int unsigned PHASE_W  = 32,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned BRAM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               cfg_load,
    input  logic [PHASE_W-1:0] cfg_tuning,
    input  logic [2:0]         cfg_mode,
    input  logic [DATA_W-1:0]  cfg_amp,
    input  logic [7:0]         cfg_duty,
    output logic [ADDR_W:0]    bram_addr,
    input  logic [DATA_W-1:0]  bram_din,
    output logic [DATA_W-1:0]  wave_out,
    output logic               wave_valid,
    output logic               sync_out
);

    logic [PHASE_W-1:0] phase;
    logic               wrap;
    logic [2:0]         mode;
    logic [DATA_W-1:0]  amp;
    logic [7:0]         duty;
    logic               unused_phase;

    dds_phase_acc #(
        .PHASE_W (PHASE_W),
        .DATA_W  (DATA_W)
    ) u_phase_acc (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cfg_load   (cfg_load),
        .cfg_tuning (cfg_tuning),
        .cfg_mode   (cfg_mode),
        .cfg_amp    (cfg_amp),
        .cfg_duty   (cfg_duty),
        .phase      (phase),
        .wrap       (wrap),
        .mode       (mode),
        .amp        (amp),
        .duty       (duty)
    );

    // Only the upper phase bits feed the waveform
    assign unused_phase = ^phase;

    logic [DATA_W-1:0] comp;
    logic              is_lut;
    logic              lut_sel;

    // Stage 0: decode mode into LUT address or a computed sample
    always_comb begin
        comp    = '0;
        is_lut  = 1'b1;
        lut_sel = LUT_SEL_SINE;
        case (mode)
            TRIANGLE: lut_sel = LUT_SEL_TRI;
            SQUARE: begin
                is_lut = 1'b0;
                comp   = phase[PHASE_W-1] ? '0 : '1;
            end
            PWM: begin
                is_lut = 1'b0;
                comp   = (phase[PHASE_W-1 -: 8] < duty) ? '1 : '0;
            end
            SAWTOOTH: begin
                is_lut = 1'b0;
                comp   = phase[PHASE_W-1 -: DATA_W];
            end
            default: ;
        endcase
    end

    assign bram_addr = {lut_sel, phase[PHASE_W-1 -: ADDR_W]};

    // Stages 1..BRAM_LAT: carry computed sample and side-band alongside the BRAM read
    logic [DATA_W-1:0]   comp_q [BRAM_LAT];
    logic [DATA_W-1:0]   amp_q  [BRAM_LAT];
    logic [BRAM_LAT-1:0] lut_q, vld_q, sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BRAM_LAT; i++) begin
                comp_q[i] <= '0;
                amp_q[i]  <= '0;
                lut_q[i]  <= 1'b0;
                vld_q[i]  <= 1'b0;
                sync_q[i] <= 1'b0;
            end
        end else begin
            comp_q[0] <= comp;
            amp_q[0]  <= amp;
            lut_q[0]  <= is_lut;
            vld_q[0]  <= en;
            sync_q[0] <= wrap & en;
            for (int i = 1; i < BRAM_LAT; i++) begin
                comp_q[i] <= comp_q[i-1];
                amp_q[i]  <= amp_q[i-1];
                lut_q[i]  <= lut_q[i-1];
                vld_q[i]  <= vld_q[i-1];
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    logic [DATA_W-1:0] samp_q, samp_amp_q;
    logic              samp_vld_q, samp_sync_q;

    // Stage BRAM_LAT+1: pick BRAM data or the delayed computed sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_q      <= '0;
            samp_amp_q  <= '0;
            samp_vld_q  <= 1'b0;
            samp_sync_q <= 1'b0;
        end else begin
            samp_q      <= lut_q[BRAM_LAT-1] ? bram_din : comp_q[BRAM_LAT-1];
            samp_amp_q  <= amp_q[BRAM_LAT-1];
            samp_vld_q  <= vld_q[BRAM_LAT-1];
            samp_sync_q <= sync_q[BRAM_LAT-1];
        end
    end

    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   scaled;

    // Amplitude scaling; all-ones amplitude is an exact bypass
    always_comb begin
        prod   = {{DATA_W{1'b0}}, samp_q} * {{DATA_W{1'b0}}, samp_amp_q};
        scaled = (&samp_amp_q) ? samp_q : prod[2*DATA_W-1:DATA_W];
    end

    // Output stage: wave_out only updates on valid samples so it holds while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wave_out   <= '0;
            wave_valid <= 1'b0;
            sync_out   <= 1'b0;
        end else begin
            wave_valid <= samp_vld_q;
            sync_out   <= samp_sync_q & samp_vld_q;
            if (samp_vld_q) begin
                wave_out <= scaled;
            end
        end
    end

endmodule

// File: tb/tb_dds_func_gen.sv
// Scoreboard bench for dds_func_gen: stimulus pushes expected samples, a
// negedge monitor pops and compares whenever wave_valid is high.
module tb_dds_func_gen;
    import func_gen_pkg::*;

    localparam int unsigned LAT = 1;
    localparam int unsigned L   = LAT + 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        cfg_load = 1'b0;
    logic [31:0] cfg_tuning = '0;
    logic [2:0]  cfg_mode = '0;
    logic [7:0]  cfg_amp = '0;
    logic [7:0]  cfg_duty = '0;
    logic [10:0] bram_addr;
    logic [7:0]  bram_din = '0;
    logic [7:0]  wave_out;
    logic        wave_valid;
    logic        sync_out;

    always #5 clk = ~clk;

    dds_func_gen #(
        .PHASE_W  (32),
        .DATA_W   (8),
        .ADDR_W   (10),
        .BRAM_LAT (LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cfg_load   (cfg_load),
        .cfg_tuning (cfg_tuning),
        .cfg_mode   (cfg_mode),
        .cfg_amp    (cfg_amp),
        .cfg_duty   (cfg_duty),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .wave_out   (wave_out),
        .wave_valid (wave_valid),
        .sync_out   (sync_out)
    );

    // Distinct, easily recognised contents for each table half
    function automatic logic [7:0] lut_val(input logic [10:0] a);
        return a[10] ? (8'hFF - a[9:2]) : (a[7:0] ^ 8'h5A);
    endfunction

    always @(posedge clk) bram_din <= lut_val(bram_addr);

    typedef struct packed {
        logic [7:0]  wave;
        logic        sync;
        logic [31:0] cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] cyc = '0;
    logic [31:0] ph = '0;
    logic        nsync = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t",
                     name, got, got, exp, exp, $time);
        end
    endfunction

    function automatic logic [7:0] model(input logic [2:0] m, input logic [31:0] p,
                                         input logic [7:0] d, input logic [7:0] a);
        logic [7:0]  s;
        logic [15:0] pr;
        case (m)
            3'd1:    s = lut_val({1'b1, p[31:22]});
            3'd2:    s = p[31] ? 8'd0 : 8'd255;
            3'd3:    s = (p[31:24] < d) ? 8'd255 : 8'd0;
            3'd4:    s = p[31:24];
            default: s = lut_val({1'b0, p[31:22]});
        endcase
        pr = {8'd0, s} * {8'd0, a};
        return (a == 8'hFF) ? s : pr[15:8];
    endfunction

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && wave_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sample: wave_out=%0d, nothing expected", wave_out);
            end else begin
                e = sb.pop_front();
                check("wave_out", {24'd0, wave_out}, {24'd0, e.wave});
                check("sync_out", {31'd0, sync_out}, {31'd0, e.sync});
                check("latency", cyc - e.cyc, L);
            end
        end else if (rst_n && sync_out) begin
            checks++;
            errors++;
            $display("FAIL sync_without_valid: sync_out=1, expected 0");
        end
    end

    // One enabled sample at the current negedge; advances to the next negedge
    task automatic step(input logic [2:0] m, input logic [7:0] a, input logic [7:0] d,
                        input logic [31:0] tw, input bit chk_addr);
        exp_t        e;
        logic [32:0] s;
        e.wave = model(m, ph, d, a);
        e.sync = nsync;
        e.cyc  = cyc;
        sb.push_back(e);
        if (chk_addr) check("bram_addr", {21'd0, bram_addr}, {21'd0, (m == TRIANGLE), ph[31:22]});
        s     = {1'b0, ph} + {1'b0, tw};
        ph    = s[31:0];
        nsync = s[32];
        @(negedge clk);
    endtask

    task automatic pause();
        en    = 1'b0;
        nsync = 1'b0;
    endtask

    task automatic drain();
        pause();
        repeat (L + 2) @(negedge clk);
        check("sb_empty", sb.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        en       = 1'b0;
        cfg_load = 1'b0;
        sb.delete();
        ph       = '0;
        nsync    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Load config with en=0 so it becomes active on the following clock
    task automatic cfg(input logic [31:0] tw, input logic [2:0] m, input logic [7:0] a,
                       input logic [7:0] d);
        cfg_tuning = tw;
        cfg_mode   = m;
        cfg_amp    = a;
        cfg_duty   = d;
        cfg_load   = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] m;
        #12;
        check("rst_wave_out", {24'd0, wave_out}, 0);
        check("rst_wave_valid", {31'd0, wave_valid}, 0);
        check("rst_sync_out", {31'd0, sync_out}, 0);
        check("rst_bram_addr", {21'd0, bram_addr}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Square, 16-sample period
        cfg(32'h1000_0000, SQUARE, 8'hFF, 8'd128);
        en = 1'b1;
        for (int k = 0; k < 40; k++) step(SQUARE, 8'hFF, 8'd128, 32'h1000_0000, 1'b0);
        drain();

        // Sine through the BRAM, address walks the whole table
        do_reset();
        cfg(32'h0040_0000, SINE, 8'hFF, 8'd128);
        en = 1'b1;
        for (int k = 0; k < 1025; k++) step(SINE, 8'hFF, 8'd128, 32'h0040_0000, 1'b1);
        drain();

        // PWM duty 64, then duty 0
        do_reset();
        cfg(32'h0100_0000, PWM, 8'hFF, 8'd64);
        en = 1'b1;
        for (int k = 0; k < 512; k++) step(PWM, 8'hFF, 8'd64, 32'h0100_0000, 1'b0);
        pause();
        cfg(32'h0100_0000, PWM, 8'hFF, 8'd0);
        en = 1'b1;
        for (int k = 0; k < 256; k++) step(PWM, 8'hFF, 8'd0, 32'h0100_0000, 1'b0);
        drain();

        // Mid-period load switches at the next wrap; a load on a wrap cycle waits a period
        do_reset();
        cfg(32'h0400_0000, SINE, 8'hFF, 8'd128);
        en = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (k == 20) begin
                cfg_mode = TRIANGLE;
                cfg_load = 1'b1;
            end else if (k == 127) begin
                cfg_mode = SQUARE;
                cfg_load = 1'b1;
            end else begin
                cfg_load = 1'b0;
            end
            m = (k < 64) ? SINE : (k < 192) ? TRIANGLE : SQUARE;
            step(m, 8'hFF, 8'd128, 32'h0400_0000, (m != SQUARE));
        end
        drain();

        // Sawtooth at half amplitude, then hold with en low
        do_reset();
        cfg(32'h1900_0000, SAWTOOTH, 8'd128, 8'd128);
        en = 1'b1;
        for (int k = 0; k < 12; k++) step(SAWTOOTH, 8'd128, 8'd128, 32'h1900_0000, 1'b0);
        pause();
        for (int i = 0; i < 10; i++) begin
            check("hold_valid", {31'd0, wave_valid}, {31'd0, (i < L)});
            if (i >= L) check("hold_wave", {24'd0, wave_out}, 32'd9);
            @(negedge clk);
        end
        drain();

        // Asynchronous reset mid-run with a pending config
        do_reset();
        cfg(32'h0100_0000, SAWTOOTH, 8'hFF, 8'd128);
        en = 1'b1;
        for (int k = 0; k < 10; k++) step(SAWTOOTH, 8'hFF, 8'd128, 32'h0100_0000, 1'b0);
        cfg_mode   = TRIANGLE;
        cfg_tuning = 32'd5;
        cfg_amp    = 8'd3;
        cfg_load   = 1'b1;
        step(SAWTOOTH, 8'hFF, 8'd128, 32'h0100_0000, 1'b0);
        cfg_load = 1'b0;
        step(SAWTOOTH, 8'hFF, 8'd128, 32'h0100_0000, 1'b0);
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        check("async_rst_wave_out", {24'd0, wave_out}, 0);
        check("async_rst_wave_valid", {31'd0, wave_valid}, 0);
        check("async_rst_sync_out", {31'd0, sync_out}, 0);
        check("async_rst_bram_addr", {21'd0, bram_addr}, 0);
        sb.delete();
        ph    = '0;
        nsync = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        en = 1'b1;
        for (int k = 0; k < 5; k++) step(SINE, 8'hFF, 8'd128, 32'd0, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
